// File: rtl/clock_failover_ctrl.sv
// Purpose: clock-health monitor and rate-limited select generator for the glitchless clock mux.
// Latency: heartbeat edge detected 3 aclk edges after hbN_in changes; selection follows health/manual changes by 1 cycle.
// Backpressure: none; after each switch, requests are ignored for HOLDOFF_CYCLES cycles.
module clock_failover_ctrl #(
  parameter int WINDOW_CYCLES  = 1024,
  parameter int MIN_EDGES      = 4,
  parameter int HOLDOFF_CYCLES = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic hb1_in,
  input  logic hb2_in,
  input  logic manual_en_in,
  input  logic manual_sel_in,
  output logic selection,
  output logic clk1_ok,
  output logic clk2_ok,
  output logic no_clock,
  output logic switch_pulse
);

  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam int EW = $clog2(MIN_EDGES + 1);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_SAT  = EW'(MIN_EDGES);
  localparam logic [EW:0]   EDGE_MIN  = (EW + 1)'(MIN_EDGES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ON1,
    ST_ON2,
    ST_HOLD
  } state_t;

  // Heartbeat pipelines: [0],[1] synchronize, [2] is the delayed copy used for edge detection.
  logic [2:0] hb1_sr;
  logic [2:0] hb2_sr;
  logic       edge1;
  logic       edge2;

  logic [WW-1:0] win_cnt;
  logic          win_term;
  logic          window_done;

  logic [EW-1:0] ecnt1;
  logic [EW-1:0] ecnt2;
  logic [EW:0]   tot1;
  logic [EW:0]   tot2;

  logic          man_en_q;
  logic          man_sel_q;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic          sel_nxt;
  logic          pulse_nxt;
  logic          tgt;
  logic          want_switch;
  logic          do_switch;

  assign edge1    = hb1_sr[1] ^ hb1_sr[2];
  assign edge2    = hb2_sr[1] ^ hb2_sr[2];
  assign win_term = (win_cnt == WIN_LAST);

  // An edge on the terminal cycle still counts toward the window being closed.
  assign tot1 = {1'b0, ecnt1} + {{EW{1'b0}}, edge1};
  assign tot2 = {1'b0, ecnt2} + {{EW{1'b0}}, edge2};

  // Synchronize both heartbeat toggles into the aclk domain.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hb1_sr <= '0;
      hb2_sr <= '0;
    end else begin
      hb1_sr <= {hb1_sr[1:0], hb1_in};
      hb2_sr <= {hb2_sr[1:0], hb2_in};
    end
  end

  // Free-running measurement window; window_done latches after the first close.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      win_cnt     <= '0;
      window_done <= 1'b0;
    end else if (win_term) begin
      win_cnt     <= '0;
      window_done <= 1'b1;
    end else begin
      win_cnt     <= win_cnt + WW'(1);
    end
  end

  // Saturating edge counters; health is latched and counters cleared at window close.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ecnt1   <= '0;
      ecnt2   <= '0;
      clk1_ok <= 1'b0;
      clk2_ok <= 1'b0;
    end else if (win_term) begin
      ecnt1   <= '0;
      ecnt2   <= '0;
      clk1_ok <= (tot1 >= EDGE_MIN);
      clk2_ok <= (tot2 >= EDGE_MIN);
    end else begin
      if (edge1 && (ecnt1 != EDGE_SAT)) ecnt1 <= ecnt1 + EW'(1);
      if (edge2 && (ecnt2 != EDGE_SAT)) ecnt2 <= ecnt2 + EW'(1);
    end
  end

  // Both-clocks-lost flag, one cycle behind the health bits; manual inputs registered once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      no_clock  <= 1'b0;
      man_en_q  <= 1'b0;
      man_sel_q <= 1'b0;
    end else begin
      no_clock  <= window_done & ~clk1_ok & ~clk2_ok;
      man_en_q  <= manual_en_in;
      man_sel_q <= manual_sel_in;
    end
  end

  // Selection FSM state, holdoff counter and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_INIT;
      hold_cnt     <= '0;
      selection    <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      selection    <= sel_nxt;
      switch_pulse <= pulse_nxt;
    end
  end

  // Target choice and next-state logic. When the holdoff expires a still-valid
  // request is taken in the same cycle, so selection stays put exactly
  // HOLDOFF_CYCLES cycles after each switch.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    sel_nxt   = selection;
    pulse_nxt = 1'b0;
    do_switch = 1'b0;

    if (man_en_q)      tgt = man_sel_q;
    else if (clk1_ok)  tgt = 1'b0;
    else if (clk2_ok)  tgt = 1'b1;
    else               tgt = selection;

    want_switch = (tgt != selection) && (tgt ? clk2_ok : clk1_ok);

    case (state)
      ST_INIT: begin
        sel_nxt = 1'b0;
        if (win_term) state_nxt = ST_ON1;
      end
      ST_ON1, ST_ON2: begin
        do_switch = want_switch;
      end
      ST_HOLD: begin
        if (hold_cnt != '0)   hold_nxt  = hold_cnt - HW'(1);
        else if (want_switch) do_switch = 1'b1;
        else                  state_nxt = selection ? ST_ON2 : ST_ON1;
      end
      default: state_nxt = ST_INIT;
    endcase

    if (do_switch) begin
      sel_nxt   = tgt;
      pulse_nxt = 1'b1;
      hold_nxt  = HOLD_LOAD;
      state_nxt = ST_HOLD;
    end
  end

endmodule

// File: tb/tb_clock_failover_ctrl.sv
// Purpose: randomized and directed check of clock_failover_ctrl against a time-based reference model.
// Latency: outputs compared 1 time unit after every aclk rising edge.
// Backpressure: n/a; stimulus is applied every cycle.
module tb_clock_failover_ctrl;

  localparam int W = 64;
  localparam int M = 4;
  localparam int H = 16;

  logic aclk = 1'b0;
  logic aresetn;
  logic hb1_in;
  logic hb2_in;
  logic manual_en_in;
  logic manual_sel_in;
  logic selection;
  logic clk1_ok;
  logic clk2_ok;
  logic no_clock;
  logic switch_pulse;

  clock_failover_ctrl #(
    .WINDOW_CYCLES (W),
    .MIN_EDGES     (M),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .hb1_in       (hb1_in),
    .hb2_in       (hb2_in),
    .manual_en_in (manual_en_in),
    .manual_sel_in(manual_sel_in),
    .selection    (selection),
    .clk1_ok      (clk1_ok),
    .clk2_ok      (clk2_ok),
    .no_clock     (no_clock),
    .switch_pulse (switch_pulse)
  );

  always #5 aclk = ~aclk;

  int vec_cnt     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge n is the n-th aclk rising edge since reset release.
  // Windows close on edges n that are multiples of W; a heartbeat level sampled
  // on edge k is seen as an edge in the count updated on edge k+2; decisions use
  // values as they stood after the previous edge; a switch at edge s blocks
  // further switches until edge s+H.
  int       m_n;
  int       m_e1, m_e2;
  int       m_last_sw;
  bit       m_ok1, m_ok2, m_done, m_noclk, m_sel, m_pulse;
  bit [2:0] m_h1, m_h2;
  bit       m_men, m_msel;

  int per1, per2, gc1, gc2, flip_pct;

  task automatic model_reset();
    m_n = 0; m_e1 = 0; m_e2 = 0; m_last_sw = -1000000;
    m_ok1 = 0; m_ok2 = 0; m_done = 0; m_noclk = 0; m_sel = 0; m_pulse = 0;
    m_h1 = '0; m_h2 = '0; m_men = 0; m_msel = 0;
  endtask

  task automatic model_edge();
    bit p_ok1, p_ok2, p_done, tgt, d1, d2;
    m_n++;
    p_ok1 = m_ok1; p_ok2 = m_ok2; p_done = m_done;

    m_pulse = 0;
    if (p_done && (m_n - m_last_sw >= H)) begin
      if (m_men)      tgt = m_msel;
      else if (p_ok1) tgt = 0;
      else if (p_ok2) tgt = 1;
      else            tgt = m_sel;
      if (tgt != m_sel && (tgt ? p_ok2 : p_ok1)) begin
        m_sel = tgt; m_pulse = 1; m_last_sw = m_n;
      end
    end
    m_noclk = p_done && !p_ok1 && !p_ok2;

    d1 = m_h1[1] ^ m_h1[2];
    d2 = m_h2[1] ^ m_h2[2];
    m_e1 += int'(d1);
    m_e2 += int'(d2);
    if (m_n % W == 0) begin
      m_ok1 = (m_e1 >= M); m_ok2 = (m_e2 >= M);
      m_e1 = 0; m_e2 = 0; m_done = 1;
    end
    m_h1 = {m_h1[1:0], hb1_in};
    m_h2 = {m_h2[1:0], hb2_in};
    m_men = manual_en_in; m_msel = manual_sel_in;
  endtask

  task automatic check_outputs();
    chk("selection", selection, m_sel);
    chk("clk1_ok", clk1_ok, m_ok1);
    chk("clk2_ok", clk2_ok, m_ok2);
    chk("no_clock", no_clock, m_noclk);
    chk("switch_pulse", switch_pulse, m_pulse);
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
    check_outputs();
    if (per1 != 0 && ++gc1 >= per1) begin hb1_in = ~hb1_in; gc1 = 0; end
    if (per2 != 0 && ++gc2 >= per2) begin hb2_in = ~hb2_in; gc2 = 0; end
    if (flip_pct != 0 && $urandom_range(0, 99) < flip_pct) manual_sel_in = ~manual_sel_in;
  endtask

  task automatic run(input int p1, input int p2, input bit men, input bit msel, input int cycles);
    per1 = p1; per2 = p2; manual_en_in = men; manual_sel_in = msel;
    repeat (cycles) step();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_selection", selection, 0);
    chk("rst_clk1_ok", clk1_ok, 0);
    chk("rst_clk2_ok", clk2_ok, 0);
    chk("rst_no_clock", no_clock, 0);
    chk("rst_switch_pulse", switch_pulse, 0);
    model_reset();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0; hb1_in = 0; hb2_in = 0; manual_en_in = 0; manual_sel_in = 0;
    per1 = 0; per2 = 0; gc1 = 0; gc2 = 0; flip_pct = 0;
    model_reset();
    #12;
    chk("init_selection", selection, 0);
    chk("init_clk1_ok", clk1_ok, 0);
    chk("init_clk2_ok", clk2_ok, 0);
    chk("init_no_clock", no_clock, 0);
    chk("init_switch_pulse", switch_pulse, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Both healthy, then clock 1 lost, then clock 1 recovers.
    run(5, 5, 0, 0, 100);
    chk("healthy_ok1", clk1_ok, 1);
    chk("healthy_ok2", clk2_ok, 1);
    run(0, 5, 0, 0, 140);
    chk("failover_sel", selection, 1);
    run(5, 5, 0, 0, 200);
    chk("recover_sel", selection, 0);

    // Manual override 0->1->0 with 4 cycles between changes, then toward a dead clock.
    run(5, 5, 1, 0, 10);
    run(5, 5, 1, 1, 4);
    run(5, 5, 1, 0, 30);
    run(5, 0, 1, 0, 140);
    run(5, 0, 1, 1, 60);
    chk("manual_dead_sel", selection, 0);

    // Threshold: clock 1 gets 4 edges with the 4th on the terminal cycle, clock 2 gets 3.
    do_reset();
    per1 = 0; per2 = 0; hb1_in = 0; hb2_in = 0; manual_en_in = 0; manual_sel_in = 0;
    for (int i = 1; i <= W; i++) begin
      if (i == 10 || i == 20 || i == 30 || i == 62) hb1_in = ~hb1_in;
      if (i == 10 || i == 20 || i == 30) hb2_in = ~hb2_in;
      step();
    end
    chk("thr_ok1_4edges", clk1_ok, 1);
    chk("thr_ok2_3edges", clk2_ok, 0);
    run(0, 0, 0, 0, 140);
    chk("dead_no_clock", no_clock, 1);
    chk("dead_sel_held", selection, 0);

    // Reset in the middle of a holdoff, then no switch before the first window close.
    run(5, 5, 1, 0, 140);
    run(5, 5, 1, 1, 6);
    chk("pre_reset_sel", selection, 1);
    do_reset();
    run(5, 5, 1, 1, 60);
    chk("post_reset_nosw", selection, 0);
    run(5, 5, 1, 1, 20);
    chk("post_reset_sw", selection, 1);

    // Randomized phases.
    repeat (40) begin
      int  p1, p2;
      bit  men;
      p1  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 24));
      p2  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 24));
      men = ($urandom_range(0, 2) == 0);
      flip_pct = men ? 3 : 0;
      if ($urandom_range(0, 9) == 0) do_reset();
      run(p1, p2, men, 1'($urandom_range(0, 1)), int'($urandom_range(20, 200)));
    end
    flip_pct = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
